// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for the hazard scoreboard: source/destination info in,
// stall, forward selects and resolved operands out.
interface hazard_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  logic                    id_valid;
  logic [REG_AW-1:0]       id_src1;
  logic [REG_AW-1:0]       id_src2;
  logic                    id_use1;
  logic                    id_use2;
  logic [REG_AW-1:0]       id_dst;
  logic                    id_wr;
  logic                    id_load;
  logic                    flush;
  logic [DATA_W-1:0]       rf_data1;
  logic [DATA_W-1:0]       rf_data2;
  logic [DEPTH*DATA_W-1:0] stage_data;
  logic                    stall;
  logic [3:0]              fwd_sel1;
  logic [3:0]              fwd_sel2;
  logic [DATA_W-1:0]       op1;
  logic [DATA_W-1:0]       op2;
  logic [CNT_W-1:0]        stall_cnt;

  // Decode drives stage info; stall is a combinational hold request, no ready side.
  modport master (
    output id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wr, id_load,
    output flush, rf_data1, rf_data2, stage_data,
    input  stall, fwd_sel1, fwd_sel2, op1, op2, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wr, id_load,
    input  flush, rf_data1, rf_data2, stage_data,
    output stall, fwd_sel1, fwd_sel2, op1, op2, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers past decode and resolves RAW hazards
// by forwarding (FWD_EN=1) or by stalling until the writer retires (FWD_EN=0).
module hazard_scoreboard #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] dst;
    logic              load;
  } entry_t;

  entry_t            pipe_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [DEPTH-1:0]  hit1;
  logic [DEPTH-1:0]  hit2;
  logic [3:0]        sel1;
  logic [3:0]        sel2;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic              hazard;
  logic              stall;

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit1[k] = bus.id_use1 & pipe_q[k].valid & pipe_q[k].wr & (pipe_q[k].dst == bus.id_src1);
      hit2[k] = bus.id_use2 & pipe_q[k].valid & pipe_q[k].wr & (pipe_q[k].dst == bus.id_src2);
    end
  end

  // Scan oldest to youngest so the lowest matching stage is the one that sticks.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    fwd1 = '0;
    fwd2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit1[k]) begin
        sel1 = 4'(k + 1);
        fwd1 = bus.stage_data[k*DATA_W +: DATA_W];
      end
      if (hit2[k]) begin
        sel2 = 4'(k + 1);
        fwd2 = bus.stage_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0) hazard = (hit1[0] | hit2[0]) & pipe_q[0].load;
    else             hazard = (|hit1) | (|hit2);
  end

  assign stall         = bus.id_valid & hazard & ~bus.flush;
  assign bus.stall     = stall;
  assign bus.fwd_sel1  = (FWD_EN != 0) ? sel1 : 4'd0;
  assign bus.fwd_sel2  = (FWD_EN != 0) ? sel2 : 4'd0;
  assign bus.op1       = (FWD_EN != 0 && sel1 != 4'd0) ? fwd1 : bus.rf_data1;
  assign bus.op2       = (FWD_EN != 0 && sel2 != 4'd0) ? fwd2 : bus.rf_data2;
  assign bus.stall_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      // A stalled or flushed decode slot becomes a bubble in execute.
      if (bus.id_valid && !stall && !bus.flush)
        pipe_q[0] <= {1'b1, bus.id_wr, bus.id_dst, bus.id_load};
      else
        pipe_q[0] <= '0;
      for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
      if (stall && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a forwarding instance and a no-forward instance
// (4-bit counter) share one stimulus; each vector checks one of them.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid, id_use1, id_use2, id_wr, id_load, flush;
  logic [2:0]  id_src1, id_src2, id_dst;
  logic [15:0] rf_data1, rf_data2;
  logic [47:0] stage_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [47:0] SD_DEF = {16'h3333, 16'h2222, 16'h1111};

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.DATA_W(16), .REG_AW(3), .DEPTH(3), .CNT_W(16)) if_f ();
  hazard_scoreboard_if #(.DATA_W(16), .REG_AW(3), .DEPTH(3), .CNT_W(4))  if_n ();

  assign if_f.id_valid = id_valid;   assign if_n.id_valid = id_valid;
  assign if_f.id_src1  = id_src1;    assign if_n.id_src1  = id_src1;
  assign if_f.id_src2  = id_src2;    assign if_n.id_src2  = id_src2;
  assign if_f.id_use1  = id_use1;    assign if_n.id_use1  = id_use1;
  assign if_f.id_use2  = id_use2;    assign if_n.id_use2  = id_use2;
  assign if_f.id_dst   = id_dst;     assign if_n.id_dst   = id_dst;
  assign if_f.id_wr    = id_wr;      assign if_n.id_wr    = id_wr;
  assign if_f.id_load  = id_load;    assign if_n.id_load  = id_load;
  assign if_f.flush    = flush;      assign if_n.flush    = flush;
  assign if_f.rf_data1 = rf_data1;   assign if_n.rf_data1 = rf_data1;
  assign if_f.rf_data2 = rf_data2;   assign if_n.rf_data2 = rf_data2;
  assign if_f.stage_data = stage_data;
  assign if_n.stage_data = stage_data;

  hazard_scoreboard #(.DATA_W(16), .REG_AW(3), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .bus(if_f.slave)
  );
  hazard_scoreboard #(.DATA_W(16), .REG_AW(3), .DEPTH(3), .FWD_EN(0), .CNT_W(4)) u_nofwd (
    .clk(clk), .rst(rst), .bus(if_n.slave)
  );

  typedef struct {
    string       name;
    bit          dut;      // 0 = forwarding instance, 1 = no-forward instance
    bit          do_reset;
    logic        valid;
    logic [2:0]  src1, src2, dst;
    logic        use1, use2, wr, load, fl;
    logic [15:0] rf1;
    logic [47:0] sd;
    logic        e_stall;
    logic [3:0]  e_sel1, e_sel2;
    logic [15:0] e_op1, e_op2;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, bit dut, bit rs, logic v, int s1, logic u1,
                              int s2, logic u2, int d, logic wr, logic ld, logic fl,
                              logic [15:0] r1, logic [47:0] sd, logic es, int e1, int e2,
                              logic [15:0] o1, logic [15:0] o2, int cnt);
    vec_t t;
    t.name = nm;  t.dut = dut;  t.do_reset = rs;  t.valid = v;
    t.src1 = 3'(s1);  t.use1 = u1;  t.src2 = 3'(s2);  t.use2 = u2;
    t.dst = 3'(d);  t.wr = wr;  t.load = ld;  t.fl = fl;  t.rf1 = r1;  t.sd = sd;
    t.e_stall = es;  t.e_sel1 = 4'(e1);  t.e_sel2 = 4'(e2);
    t.e_op1 = o1;  t.e_op2 = o2;  t.e_cnt = 16'(cnt);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    id_valid = 1'b0; id_use1 = 1'b0; id_use2 = 1'b0; id_wr = 1'b0; id_load = 1'b0;
    flush = 1'b0; id_src1 = '0; id_src2 = '0; id_dst = '0;
    rf_data1 = 16'h1234; rf_data2 = 16'h5678; stage_data = SD_DEF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.valid; id_src1 = t.src1; id_use1 = t.use1; id_src2 = t.src2;
    id_use2 = t.use2; id_dst = t.dst; id_wr = t.wr; id_load = t.load; flush = t.fl;
    rf_data1 = t.rf1; rf_data2 = 16'h5678; stage_data = t.sd;
  endtask

  task automatic check_vec(input vec_t t);
    if (t.dut) begin
      chk({t.name, ".stall"}, 32'(if_n.stall),     32'(t.e_stall));
      chk({t.name, ".sel1"},  32'(if_n.fwd_sel1),  32'(t.e_sel1));
      chk({t.name, ".sel2"},  32'(if_n.fwd_sel2),  32'(t.e_sel2));
      chk({t.name, ".op1"},   32'(if_n.op1),       32'(t.e_op1));
      chk({t.name, ".op2"},   32'(if_n.op2),       32'(t.e_op2));
      chk({t.name, ".cnt"},   32'(if_n.stall_cnt), 32'(t.e_cnt));
    end else begin
      chk({t.name, ".stall"}, 32'(if_f.stall),     32'(t.e_stall));
      chk({t.name, ".sel1"},  32'(if_f.fwd_sel1),  32'(t.e_sel1));
      chk({t.name, ".sel2"},  32'(if_f.fwd_sel2),  32'(t.e_sel2));
      chk({t.name, ".op1"},   32'(if_f.op1),       32'(t.e_op1));
      chk({t.name, ".op2"},   32'(if_f.op2),       32'(t.e_op2));
      chk({t.name, ".cnt"},   32'(if_f.stall_cnt), 32'(t.e_cnt));
    end
  endtask

  initial begin
    // Forwarding instance: ALU RAW, load-use, youngest priority, flush over hazard.
    //                  name        dut rs v  s1 u1 s2 u2 d wr ld fl rf1       sd                                  st s1 s2 op1       op2       cnt
    vecs.push_back(mk("idle",       0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234, SD_DEF,                             0, 0, 0, 16'h1234, 16'h5678, 0));
    vecs.push_back(mk("add_r3",     0, 0, 1, 1, 1, 2, 1, 3, 1, 0, 0, 16'h1234, SD_DEF,                             0, 0, 0, 16'h1234, 16'h5678, 0));
    vecs.push_back(mk("sub_fwd0",   0, 0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 16'h1234, {16'h3333, 16'h2222, 16'h00AA},     0, 1, 0, 16'h00AA, 16'h5678, 0));
    vecs.push_back(mk("sub_fwd1",   0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 16'h1234, SD_DEF,                             0, 2, 0, 16'h2222, 16'h5678, 0));
    vecs.push_back(mk("ld_r2",      0, 0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 16'h1234, SD_DEF,                             0, 0, 0, 16'h1234, 16'h5678, 0));
    vecs.push_back(mk("lu_stall",   0, 0, 1, 0, 0, 2, 1, 2, 1, 0, 0, 16'h1234, SD_DEF,                             1, 0, 1, 16'h1234, 16'h1111, 0));
    vecs.push_back(mk("lu_fwd",     0, 0, 1, 0, 0, 2, 1, 2, 1, 0, 0, 16'h1234, {16'h3333, 16'hBEEF, 16'h1111},     0, 0, 2, 16'h1234, 16'hBEEF, 1));
    vecs.push_back(mk("w_r5a",      0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 16'h1234, SD_DEF,                             0, 0, 0, 16'h1234, 16'h5678, 1));
    vecs.push_back(mk("w_r6",       0, 0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 16'h1234, SD_DEF,                             0, 0, 0, 16'h1234, 16'h5678, 1));
    vecs.push_back(mk("w_r5b",      0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 16'h1234, SD_DEF,                             0, 0, 0, 16'h1234, 16'h5678, 1));
    vecs.push_back(mk("youngest",   0, 0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 16'h1234, {16'h0001, 16'h2222, 16'h0002},     0, 1, 2, 16'h0002, 16'h2222, 1));
    vecs.push_back(mk("ld_r1",      0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 16'h1234, SD_DEF,                             0, 0, 0, 16'h1234, 16'h5678, 1));
    vecs.push_back(mk("flush_lu",   0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 1, 16'h1234, SD_DEF,                             0, 1, 0, 16'h1111, 16'h5678, 1));
    vecs.push_back(mk("post_flush", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h1234, SD_DEF,                             0, 2, 0, 16'h2222, 16'h5678, 1));
    // No-forward instance: adjacent dependency stalls DEPTH cycles, independent pair does not.
    vecs.push_back(mk("n_idle",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234, SD_DEF,                             0, 0, 0, 16'h1234, 16'h5678, 0));
    vecs.push_back(mk("n_w3",       1, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 16'h1234, SD_DEF,                             0, 0, 0, 16'h1234, 16'h5678, 0));
    vecs.push_back(mk("n_dep0",     1, 0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 16'h1234, SD_DEF,                             1, 0, 0, 16'h1234, 16'h5678, 0));
    vecs.push_back(mk("n_dep1",     1, 0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 16'h1234, SD_DEF,                             1, 0, 0, 16'h1234, 16'h5678, 1));
    vecs.push_back(mk("n_dep2",     1, 0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 16'h1234, SD_DEF,                             1, 0, 0, 16'h1234, 16'h5678, 2));
    vecs.push_back(mk("n_rel",      1, 0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 16'hCAFE, SD_DEF,                             0, 0, 0, 16'hCAFE, 16'h5678, 3));
    vecs.push_back(mk("n_indep",    1, 0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 16'h1234, SD_DEF,                             0, 0, 0, 16'h1234, 16'h5678, 3));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_reset) do_reset();
      drive(vecs[i]);
      #4;
      check_vec(vecs[i]);
      @(posedge clk);
      #1;
    end

    // Self-dependent ALU op held in decode: no-forward stalls 3 of every 4 cycles
    // after the first, the forwarding instance never stalls.
    do_reset();
    id_valid = 1'b1; id_src1 = 3'd3; id_use1 = 1'b1; id_src2 = 3'd0; id_use2 = 1'b0;
    id_dst = 3'd3; id_wr = 1'b1; id_load = 1'b0; flush = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #4;
    chk("sat.early_stall", 32'(if_n.stall), 32'd1);
    chk("sat.early_cnt",   32'(if_n.stall_cnt), 32'd6);
    repeat (26) begin @(posedge clk); #1; end
    #4;
    chk("sat.mid_stall",   32'(if_n.stall), 32'd1);
    chk("sat.cnt_sat",     32'(if_n.stall_cnt), 32'hF);
    chk("sat.fwd_cnt",     32'(if_f.stall_cnt), 32'd0);
    chk("sat.fwd_sel1",    32'(if_f.fwd_sel1), 32'd1);
    chk("sat.fwd_op1",     32'(if_f.op1), 32'h1111);

    // Reset lands mid-stall, away from any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst.stall",   32'(if_n.stall), 32'd0);
    chk("rst.cnt",     32'(if_n.stall_cnt), 32'd0);
    chk("rst.fwd_sel", 32'(if_f.fwd_sel1), 32'd0);
    chk("rst.fwd_op1", 32'(if_f.op1), 32'h1234);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst.after_stall", 32'(if_n.stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
